// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding and scan-enable constants for the scan chain controller
package scan_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        CAPTURE   = 3'd2,
        SHIFT_OUT = 3'd3,
        DONE      = 3'd4
    } scan_state_t;

    localparam logic SE_SHIFT   = 1'b1;
    localparam logic SE_CAPTURE = 1'b0;

endpackage

// File: rtl/scan_bit_counter.sv
// rtl/scan_bit_counter.sv - shift-position counter; tc flags the last bit of a chain pass
module scan_bit_counter #(
    parameter  int CHAIN_LEN = 8,
    localparam int CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CHAIN_LEN - 1);

    logic [CNT_W-1:0] count;

    // Wrapping at terminal count returns the counter to 0 as each shift state exits.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - scan load/capture/unload controller; SCAN_CMP_EN adds expected/pass compare
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    output logic                 SE,
    output logic                 SD,
    input  logic                 SO,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response
`ifdef SCAN_CMP_EN
    ,
    input  logic [CHAIN_LEN-1:0] expected,
    output logic                 pass
`endif
);

    scan_state_t          state;
    scan_state_t          state_next;
    logic                 tc;
    logic                 start_acc;
    logic                 cnt_en;
    logic [CHAIN_LEN-1:0] load_sr;
    logic [CHAIN_LEN-1:0] response_next;

    scan_bit_counter #(
        .CHAIN_LEN(CHAIN_LEN)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .clr  (start_acc),
        .en   (cnt_en),
        .tc   (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode only the state and load register flops.
    always_comb begin
        state_next = state;
        SE         = SE_CAPTURE;
        busy       = 1'b1;
        done       = 1'b0;
        cnt_en     = 1'b0;
        start_acc  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = SHIFT_IN;
                end
            end
            SHIFT_IN: begin
                SE     = SE_SHIFT;
                cnt_en = 1'b1;
                if (tc) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                SE     = SE_SHIFT;
                cnt_en = 1'b1;
                if (tc) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // MSB leaves first; zero fill everywhere outside the load phase.
    assign SD            = (state == SHIFT_IN) & load_sr[CHAIN_LEN-1];
    assign response_next = {response[CHAIN_LEN-2:0], SO};

    always_ff @(posedge clk) begin
        if (reset) begin
            load_sr <= '0;
        end else if (start_acc) begin
            load_sr <= pattern;
        end else if (state == SHIFT_IN) begin
            load_sr <= {load_sr[CHAIN_LEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            response <= '0;
        end else if (state == SHIFT_OUT) begin
            response <= response_next;
        end
    end

`ifdef SCAN_CMP_EN
    logic [CHAIN_LEN-1:0] expected_q;

    // Verdict is taken from the final unload value so it is valid alongside done.
    always_ff @(posedge clk) begin
        if (reset) begin
            expected_q <= '0;
            pass       <= 1'b0;
        end else begin
            if (start_acc) begin
                expected_q <= expected;
            end
            if (state == SHIFT_OUT && tc) begin
                pass <= (response_next == expected_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - directed bench for scan_chain_ctrl with an 8-FF scan chain model
module tb_scan_chain_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic       SE;
    logic       SD;
    logic       SO;
    logic       busy;
    logic       done;
    logic [7:0] response;
`ifdef SCAN_CMP_EN
    logic [7:0] expected;
    logic       pass;
`endif

    logic [7:0] chain = 8'h00;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // FF0.D = 0, FF[i].D = ~FF[i-1].Q
    always @(posedge clk) begin
        chain <= SE ? {chain[6:0], SD} : {~chain[6:0], 1'b0};
    end
    assign SO = chain[7];

    scan_chain_ctrl #(.CHAIN_LEN(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .SE      (SE),
        .SD      (SD),
        .SO      (SO),
        .busy    (busy),
        .done    (done),
        .response(response)
`ifdef SCAN_CMP_EN
        ,
        .expected(expected),
        .pass    (pass)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain run; 1: extra start pulses in SHIFT_IN cycle 3 and CAPTURE; 2: start held high
    task automatic run_scan(input string tag, input logic [7:0] pat, input logic [7:0] exp_resp,
                            input int mode, input logic [7:0] cmp, input logic exp_pass);
        logic [7:0]  sd_seq;
        logic [19:0] se_seq;
        logic [19:0] busy_seq;
        logic        sd_other;
        logic [7:0]  resp_at_done;
        logic        pass_at_done;
        int          done_cnt;
        int          done_at;
        sd_seq       = '0;
        se_seq       = '0;
        busy_seq     = '0;
        sd_other     = 1'b0;
        resp_at_done = '0;
        pass_at_done = 1'b0;
        done_cnt     = 0;
        done_at      = 0;
        pattern      = pat;
`ifdef SCAN_CMP_EN
        expected     = cmp;
`endif
        start        = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            se_seq[n-1]   = SE;
            busy_seq[n-1] = busy;
            if (n <= 8) sd_seq[8-n] = SD;
            else if (n <= 18) sd_other = sd_other | SD;
            if (done === 1'b1) begin
                done_cnt++;
                done_at      = n;
                resp_at_done = response;
`ifdef SCAN_CMP_EN
                pass_at_done = pass;
`endif
            end
            if (mode != 2) start = (mode == 1) && (n == 4 || n == 9);
            if (mode == 1) pattern = ~pat;
        end
        chk({tag, "_sd_seq"}, 32'(sd_seq), 32'(pat));
        chk({tag, "_sd_zero"}, 32'(sd_other), 32'h0);
        chk({tag, "_se_trace"}, 32'(se_seq[18:0]), 32'h1FEFF);
        chk({tag, "_busy_trace"}, 32'(busy_seq), (mode == 2) ? 32'hBFFFF : 32'h3FFFF);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_at"}, 32'(done_at), 32'd18);
        chk({tag, "_resp_done"}, 32'(resp_at_done), 32'(exp_resp));
        chk({tag, "_resp_hold"}, 32'(response), 32'(exp_resp));
`ifdef SCAN_CMP_EN
        chk({tag, "_pass"}, 32'(pass_at_done), 32'(exp_pass));
`else
        if (cmp != 8'h00 || exp_pass) pass_at_done = 1'b0;
`endif
        if (mode == 2) begin
            start = 1'b0;
            repeat (22) step();
        end
    endtask

    initial begin
        logic done_seen;
        reset   = 1'b1;
        start   = 1'b0;
        pattern = 8'h00;
`ifdef SCAN_CMP_EN
        expected = 8'h00;
`endif
        repeat (3) step();
        chk("rst_se", 32'(SE), 32'h0);
        chk("rst_sd", 32'(SD), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_resp", 32'(response), 32'h0);
`ifdef SCAN_CMP_EN
        chk("rst_pass", 32'(pass), 32'h0);
`endif
        reset = 1'b0;
        step();

        run_scan("p00", 8'h00, 8'hFE, 0, 8'hFE, 1'b1);
        repeat (3) step();
        chk("idle_hold", 32'(response), 32'hFE);
        run_scan("pFF", 8'hFF, 8'h00, 0, 8'h00, 1'b1);
        run_scan("pA5_ok", 8'hA5, 8'hB4, 0, 8'hB4, 1'b1);
        run_scan("pA5_bad", 8'hA5, 8'hB4, 0, 8'hB5, 1'b0);
        run_scan("p3C_pulse", 8'h3C, 8'h86, 1, 8'h86, 1'b1);
        run_scan("pA5_hold", 8'hA5, 8'hB4, 2, 8'hB4, 1'b1);

        // reset during SHIFT_OUT cycle 4
        pattern = 8'h3C;
        start   = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            step();
            start = 1'b0;
        end
        reset = 1'b1;
        step();
        chk("mid_rst_se", 32'(SE), 32'h0);
        chk("mid_rst_sd", 32'(SD), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        chk("mid_rst_resp", 32'(response), 32'h0);
        reset     = 1'b0;
        done_seen = 1'b0;
        repeat (20) begin
            step();
            done_seen = done_seen | done;
        end
        chk("mid_rst_no_done", 32'(done_seen), 32'h0);
        run_scan("p3C_after_rst", 8'h3C, 8'h86, 0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
